mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//  Parametrised multi-mode counter: up/down, programmable terminal, wrap/saturate/one-shot modes,
//  synchronous clear and parallel load, one-cycle terminal-count pulse. Replaces the fixed up-only
//  counter in the game timers: dealer delay, blink timing, and card-index stepping.
// PARAMETERS
//  WIDTH       16  counter, top and load width in bits
//  PRESCALE_W  8   prescaler divide-ratio width; used only when MODCNT_PRESCALE_EN is defined
// PORTS
//  clk           in   1             rising-edge clock
//  reset         in   1             asynchronous, active-low; 0 clears all state immediately
//  enable        in   1             1 = count steps permitted; 0 freezes value, state and prescaler
//  clear         in   1             synchronous: value<=0, done<=0
//  load          in   1             synchronous: value<=load_value, done<=0
//  load_value    in   WIDTH         value captured on load
//  up            in   1             1 = count up (terminal = top); 0 = count down (terminal = 0)
//  mode          in   2             mode_e: 0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (acts as WRAP)
//  top           in   WIDTH         upper bound, sampled every cycle
//  prescale_div  in   PRESCALE_W    step every prescale_div+1 enabled cycles; ignored without macro
//  value         out  WIDTH         current count, registered
//  tc            out  1             one-cycle pulse, registered, on the edge value becomes terminal
//  done          out  1             ONESHOT terminal reached; level, held until clear/load
// BEHAVIOUR
//  - Reset (reset=0): value=0, tc=0, done=0, state=RUN, prescaler=0; applies without a clock edge.
//  - Priority per edge: clear > load > step. clear/load act regardless of enable and prescaler tick.
//    Both clear and load reset the prescaler count; neither asserts tc.
//  - Step happens when enable=1 && tick=1 && state=RUN. tick=1 every cycle without the macro.
//  - Up step: value>=top is terminal-exceeded. WRAP: value<top -> value+1, else -> 0.
//    SAT/ONESHOT: value<top -> value+1, else hold.
//  - Down step: WRAP: value>0 -> value-1, else -> top. SAT/ONESHOT: value>0 -> value-1, else hold.
//  - tc=1 for the single clk after an edge where a step changes value to the terminal
//    (top up, 0 down). top=0 in WRAP: each step 0->0 still pulses tc. Holding at terminal,
//    wrapping out of terminal, and loading a terminal value do not pulse tc.
//  - States: RUN, DONE. RUN->DONE when ONESHOT step reaches terminal (done=1 same edge as tc).
//    DONE->RUN only on clear or load. In DONE, steps ignored; value held.
//  - up, mode, and top changes take effect on the next step; no realignment of the current value.
//  - tc and done are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  MODCNT_PRESCALE_EN defined: tick_prescaler instance. It counts enabled cycles 0..prescale_div.
//    tick=1 on the cycle the count equals prescale_div, then the count returns to 0.
//    prescale_div=0 gives a tick every enabled cycle.
//  Undefined: no prescaler logic, tick tied to 1, prescale_div unconnected.
// STRUCTURE
//  mod_counter_pkg: typedef enum logic[1:0] mode_e {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD};
//    typedef enum logic state_e {ST_RUN, ST_DONE}.
//  Sub-module tick_prescaler #(PRESCALE_W) (clk, reset, enable, restart, div, tick).
//  It is instantiated only under MODCNT_PRESCALE_EN.
// TESTING
//  1 WRAP up, top=3, enable=1 from value 0 -> value 1,2,3,0,1,2,3;
//    tc high exactly on the cycles value=3; done=0.
//  2 SAT down, load 2, then enable -> value 2,1,0,0,0; tc high once, on the first cycle value=0.
//  3 ONESHOT up, top=5 -> value stops at 5, done=1 with tc, later steps ignored;
//    clear -> value=0, done=0, counting resumes.
//  4 clear and load same edge -> value=0; load 9 with top=5 WRAP up -> next step value=0, no tc.
//  5 reset=0 mid-count at value 7, between edges -> value=0, tc=0, done=0 before the next edge.
//    reset=1 -> counting restarts from 0.
//  6 [MODCNT_PRESCALE_EN] prescale_div=3, WRAP up top=9 -> value steps every 4 enabled cycles;
//    enable=0 for 2 cycles stretches the interval by 2; prescale_div=0 steps every cycle.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types for mod_counter: counting modes and run/done state.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler: counts enabled cycles 0..div, tick asserted while count equals div.
// Instantiated by mod_counter only when MODCNT_PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = (count == div);

  // >= rather than == so a div lowered below the running count recovers at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= (count >= div) ? '0 : count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down counter with WRAP/SAT/ONESHOT modes, clear/load and a tc pulse.
// Optional step prescaler is built in when MODCNT_PRESCALE_EN is defined.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      top,
  input  logic [PRESCALE_W-1:0] prescale_div,
  output logic [WIDTH-1:0]      value,
  output logic                  tc,
  output logic                  done
);

  state_e           state, state_nxt;
  mode_e            mode_q;
  logic [WIDTH-1:0] value_nxt;
  logic             tc_nxt;
  logic             tick;
  logic             step;
  logic             wrap_mode;

`ifdef MODCNT_PRESCALE_EN
  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .restart(clear | load),
    .div    (prescale_div),
    .tick   (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_div;
  assign tick            = 1'b1;
`endif

  assign mode_q    = mode_e'(mode);
  assign wrap_mode = (mode_q == MODE_WRAP) || (mode_q == MODE_RSVD);
  assign step      = enable && tick && (state == ST_RUN);
  assign done      = (state == ST_DONE);

  always_comb begin
    value_nxt = value;
    tc_nxt    = 1'b0;
    state_nxt = state;
    if (clear) begin
      value_nxt = '0;
      state_nxt = ST_RUN;
    end else if (load) begin
      value_nxt = load_value;
      state_nxt = ST_RUN;
    end else if (step) begin
      // tc only when the step actually moved (or wrapped) onto the terminal
      if (up) begin
        if (value < top) begin
          value_nxt = value + WIDTH'(1);
        end else if (wrap_mode) begin
          value_nxt = '0;
        end
        tc_nxt = ((value < top) || wrap_mode) && (value_nxt == top);
      end else begin
        if (value != '0) begin
          value_nxt = value - WIDTH'(1);
        end else if (wrap_mode) begin
          value_nxt = top;
        end
        tc_nxt = ((value != '0) || wrap_mode) && (value_nxt == '0);
      end
      if (tc_nxt && (mode_q == MODE_ONESHOT)) begin
        state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      tc    <= 1'b0;
    end else begin
      value <= value_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Randomised + directed bench for mod_counter with a scoreboard queue and a
// spec-level reference model; define MODCNT_PRESCALE_EN to also exercise the prescaler.
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, clear, load, up;
  logic [W-1:0]  load_value, top;
  logic [1:0]    mode;
  logic [PW-1:0] prescale_div;
  logic [W-1:0]  value;
  logic          tc, done;

  typedef struct {
    logic [W-1:0] v;
    logic         tc;
    logic         done;
    string        tag;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  string tag = "reset";
  event  async_ev;

  // reference model state
  int m_val  = 0;
  bit m_tc   = 0;
  bit m_done = 0;
  int m_pcnt = 0;

  mod_counter #(
    .WIDTH     (W),
    .PRESCALE_W(PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .up          (up),
    .mode        (mode),
    .top         (top),
    .prescale_div(prescale_div),
    .value       (value),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (value !== e.v || tc !== e.tc || done !== e.done) begin
        errors++;
        $display("FAIL %s @%0t: got value=%0d tc=%b done=%b, expected value=%0d tc=%b done=%b",
                 e.tag, $time, value, tc, done, e.v, e.tc, e.done);
      end
    end
  endtask

  always @(negedge clk) check_one();
  always @(async_ev) check_one();

  task automatic push_exp();
    exp_t e;
    e.v    = W'(m_val);
    e.tc   = m_tc;
    e.done = m_done;
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Behaviour of one clock edge, straight from the counter's rules
  task automatic model_edge();
    bit tick;
    int nv;
    int term;
    bit wrapm;
    m_tc = 0;
    if (!reset) begin
      m_val = 0; m_done = 0; m_pcnt = 0;
      return;
    end
`ifdef MODCNT_PRESCALE_EN
    tick = (m_pcnt == int'(prescale_div));
    if (clear || load) m_pcnt = 0;
    else if (enable) m_pcnt = tick ? 0 : m_pcnt + 1;
`else
    tick = 1;
`endif
    if (clear) begin
      m_val = 0; m_done = 0;
    end else if (load) begin
      m_val = int'(load_value); m_done = 0;
    end else if (enable && tick && !m_done) begin
      wrapm = (mode == 2'd0) || (mode == 2'd3);
      if (up) begin
        term = int'(top);
        if (m_val < term) nv = m_val + 1;
        else nv = wrapm ? 0 : m_val;
      end else begin
        term = 0;
        if (m_val > 0) nv = m_val - 1;
        else nv = wrapm ? int'(top) : m_val;
      end
      m_tc = (nv == term) && ((nv != m_val) || (wrapm && top == '0));
      m_val = nv;
      if (m_tc && mode == 2'd2) m_done = 1;
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      push_exp();
      #1;
    end
  endtask

  task automatic drive(input bit en, input bit clr, input bit ld, input int lv,
                       input bit u, input int md, input int tp);
    enable     = en;
    clear      = clr;
    load       = ld;
    load_value = W'(lv);
    up         = u;
    mode       = 2'(md);
    top        = W'(tp);
  endtask

  initial begin
    reset = 1'b0;
    prescale_div = '0;
    drive(0, 0, 0, 0, 1, 0, 0);
    tag = "reset_state";
    cyc(2);
    reset = 1'b1;

    tag = "wrap_up_top3";
    drive(1, 0, 0, 0, 1, 0, 3);
    cyc(8);

    tag = "sat_down";
    drive(0, 0, 1, 2, 0, 1, 3);
    cyc(1);
    drive(1, 0, 0, 0, 0, 1, 3);
    cyc(5);

    tag = "oneshot_up";
    drive(0, 1, 0, 0, 1, 2, 5);
    cyc(1);
    drive(1, 0, 0, 0, 1, 2, 5);
    cyc(8);
    tag = "oneshot_clear";
    drive(1, 1, 0, 0, 1, 2, 5);
    cyc(1);
    drive(1, 0, 0, 0, 1, 2, 5);
    cyc(3);

    tag = "clear_over_load";
    drive(1, 1, 1, 9, 1, 0, 5);
    cyc(1);
    tag = "load_above_top";
    drive(1, 0, 1, 9, 1, 0, 5);
    cyc(1);
    drive(1, 0, 0, 0, 1, 0, 5);
    cyc(2);

    tag = "wrap_top0";
    drive(1, 0, 0, 0, 1, 0, 0);
    cyc(3);
    drive(1, 0, 0, 0, 0, 3, 0);
    cyc(2);

    tag = "async_reset";
    drive(1, 1, 0, 0, 1, 0, 9);
    cyc(1);
    drive(1, 0, 0, 0, 1, 0, 9);
    cyc(7);
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_edge();
    push_exp();
    #1;
    ->async_ev;
    cyc(1);
    reset = 1'b1;
    tag = "after_reset";
    cyc(3);

`ifdef MODCNT_PRESCALE_EN
    tag = "prescale_div3";
    prescale_div = 8'd3;
    drive(1, 1, 0, 0, 1, 0, 9);
    cyc(1);
    drive(1, 0, 0, 0, 1, 0, 9);
    cyc(10);
    tag = "prescale_stall";
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(8);
    tag = "prescale_div0";
    prescale_div = '0;
    cyc(5);
`endif

    tag = "random";
    for (int i = 0; i < 1500; i++) begin
      int r;
      int tp;
      r  = int'($urandom_range(0, 99));
      tp = ($urandom_range(0, 19) == 0) ? 65535 : int'($urandom_range(0, 12));
      drive(r < 85, r >= 95, (r >= 90 && r < 95),
            ($urandom_range(0, 3) == 0) ? 65535 - int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), tp);
`ifdef MODCNT_PRESCALE_EN
      if ($urandom_range(0, 49) == 0) prescale_div = PW'($urandom_range(0, 3));
`endif
      cyc(int'($urandom_range(1, 4)));
    end

    repeat (4) begin
      if (q.size() > 0) @(negedge clk);
    end
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
